// File: rtl/bcd_clock_counter.sv
// Synchronous BCD HH:MM:SS time-of-day counter with prescaler, up/down, 12/24 h and load.
// Optional alarm compare is enabled by defining ALARM_CLOCK_EN.
module bcd_clock_counter #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter bit          HR12     = 1'b0
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        run,
   input  logic        dir,
   input  logic        load,
   input  logic [23:0] load_data,
   input  logic        load_pm,
   output logic [23:0] data,
   output logic        pm,
   output logic        day_carry,
   output logic        load_err,
   input  logic        alarm_set,
   input  logic [23:0] alarm_data,
   input  logic        alarm_pm,
   output logic        alarm_hit
);

   localparam int unsigned    PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PMAX     = PW'(TICK_DIV - 1);
   localparam logic [23:0]    RST_TIME = HR12 ? 24'h120000 : 24'h000000;

   function automatic logic [7:0] inc8(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] dec8(input logic [7:0] v);
      return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic valid_time(input logic [23:0] t);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < 6; i++)
         if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
      if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
      if (HR12) begin
         if (t[23:16] == 8'h00 || t[23:20] > 4'd1 || (t[23:20] == 4'd1 && t[19:16] > 4'd2))
            ok = 1'b0;
      end else if (t[23:20] > 4'd2 || (t[23:20] == 4'd2 && t[19:16] > 4'd3)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

   logic [PW-1:0] pcnt;
   logic [7:0]    hh, mm, ss, nxt_hh, nxt_mm, nxt_ss;
   logic          nxt_pm, nxt_day;
   logic          step, step_taken, load_ok, alarm_bad;

   assign hh         = data[23:16];
   assign mm         = data[15:8];
   assign ss         = data[7:0];
   assign step       = run && (pcnt == PMAX);
   assign step_taken = step && !load;
   assign load_ok    = valid_time(load_data);

   // 12 h wraps at 12->01 (no pm change) and 11<->12 (pm toggle); the day pulse
   // comes from the toggle that crosses midnight.
   always_comb begin
      nxt_hh  = hh;
      nxt_mm  = mm;
      nxt_ss  = ss;
      nxt_pm  = pm;
      nxt_day = 1'b0;
      if (!dir) begin
         if (ss != 8'h59) nxt_ss = inc8(ss);
         else begin
            nxt_ss = 8'h00;
            if (mm != 8'h59) nxt_mm = inc8(mm);
            else begin
               nxt_mm = 8'h00;
               if (HR12) begin
                  if (hh == 8'h12) nxt_hh = 8'h01;
                  else if (hh == 8'h11) begin
                     nxt_hh  = 8'h12;
                     nxt_pm  = ~pm;
                     nxt_day = pm;
                  end else nxt_hh = inc8(hh);
               end else if (hh == 8'h23) begin
                  nxt_hh  = 8'h00;
                  nxt_day = 1'b1;
               end else nxt_hh = inc8(hh);
            end
         end
      end else begin
         if (ss != 8'h00) nxt_ss = dec8(ss);
         else begin
            nxt_ss = 8'h59;
            if (mm != 8'h00) nxt_mm = dec8(mm);
            else begin
               nxt_mm = 8'h59;
               if (HR12) begin
                  if (hh == 8'h01) nxt_hh = 8'h12;
                  else if (hh == 8'h12) begin
                     nxt_hh  = 8'h11;
                     nxt_pm  = ~pm;
                     nxt_day = ~pm;
                  end else nxt_hh = dec8(hh);
               end else if (hh == 8'h00) begin
                  nxt_hh  = 8'h23;
                  nxt_day = 1'b1;
               end else nxt_hh = dec8(hh);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         pcnt      <= '0;
         data      <= RST_TIME;
         pm        <= 1'b0;
         day_carry <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         day_carry <= 1'b0;
         load_err  <= (load && !load_ok) || alarm_bad;
         if (load && load_ok) begin
            data <= load_data;
            pm   <= HR12 ? load_pm : 1'b0;
            pcnt <= '0;
         end else if (run) begin
            if (step) begin
               pcnt <= '0;
               // a rejected load still suppresses the coincident step
               if (!load) begin
                  data      <= {nxt_hh, nxt_mm, nxt_ss};
                  pm        <= nxt_pm;
                  day_carry <= nxt_day;
               end
            end else begin
               pcnt <= pcnt + 1'b1;
            end
         end
      end
   end

`ifdef ALARM_CLOCK_EN
   logic [23:0] alarm_time;
   logic        alarm_p, alarm_valid, alarm_ok;

   assign alarm_ok  = valid_time(alarm_data);
   assign alarm_bad = alarm_set && !alarm_ok;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         alarm_time  <= '0;
         alarm_p     <= 1'b0;
         alarm_valid <= 1'b0;
         alarm_hit   <= 1'b0;
      end else begin
         alarm_hit <= step_taken && alarm_valid &&
                      ({nxt_pm, nxt_hh, nxt_mm, nxt_ss} == {alarm_p, alarm_time});
         if (alarm_set && alarm_ok) begin
            alarm_time  <= alarm_data;
            alarm_p     <= HR12 ? alarm_pm : 1'b0;
            alarm_valid <= 1'b1;
         end
      end
   end
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_set, alarm_data, alarm_pm, step_taken};
   assign alarm_bad    = 1'b0;
   assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Directed bench for bcd_clock_counter: a 24 h and a 12 h instance share stimulus, TICK_DIV=4.
module tb_bcd_clock_counter;

`ifdef ALARM_CLOCK_EN
   localparam bit ALM = 1'b1;
`else
   localparam bit ALM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0, dir = 1'b0, load = 1'b0, load_pm = 1'b0;
   logic [23:0] load_data = '0;
   logic        alarm_set = 1'b0, alarm_pm = 1'b0;
   logic [23:0] alarm_data = '0;

   logic [23:0] data0, data1;
   logic        pm0, pm1, day0, day1, err0, err1, hit0, hit1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bcd_clock_counter #(.TICK_DIV(4), .HR12(1'b0)) dut0 (
      .CLK(clk), .reset(reset), .run(run), .dir(dir), .load(load),
      .load_data(load_data), .load_pm(load_pm), .data(data0), .pm(pm0),
      .day_carry(day0), .load_err(err0), .alarm_set(alarm_set),
      .alarm_data(alarm_data), .alarm_pm(alarm_pm), .alarm_hit(hit0));

   bcd_clock_counter #(.TICK_DIV(4), .HR12(1'b1)) dut1 (
      .CLK(clk), .reset(reset), .run(run), .dir(dir), .load(load),
      .load_data(load_data), .load_pm(load_pm), .data(data1), .pm(pm1),
      .day_carry(day1), .load_err(err1), .alarm_set(alarm_set),
      .alarm_data(alarm_data), .alarm_pm(alarm_pm), .alarm_hit(hit1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [23:0] t, input logic p);
      load      = 1'b1;
      load_data = t;
      load_pm   = p;
      @(negedge clk);
      load      = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b0;
      run = 1'b1;
      tick(3);
      check("rst_data0", data0, 24'h000000);
      check("rst_pm0", pm0, 1'b0);
      check("rst_pulses0", {day0, err0, hit0}, 3'b000);
      check("rst_pmdata1", {pm1, data1}, {1'b0, 24'h120000});
      check("rst_pulses1", {day1, err1, hit1}, 3'b000);

      // first step after release
      reset = 1'b1;
      tick(3);
      check("pre_step", data0, 24'h000000);
      tick(1);
      check("first_step0", data0, 24'h000001);
      check("first_step1", {pm1, data1}, {1'b0, 24'h120001});

      // 24 h up across midnight
      do_load(24'h235958, 1'b0);
      check("load_23", data0, 24'h235958);
      check("load_23_err12", err1, 1'b1);
      tick(3);
      check("hold_23", data0, 24'h235958);
      tick(1);
      check("up_235959", data0, 24'h235959);
      check("up_noday", day0, 1'b0);
      tick(4);
      check("up_wrap", data0, 24'h000000);
      check("up_day", day0, 1'b1);
      tick(1);
      check("up_day_1cyc", day0, 1'b0);

      // 24 h down across midnight
      dir = 1'b1;
      do_load(24'h000000, 1'b0);
      check("load_00_err12", err1, 1'b1);
      check("load_00_err24", err0, 1'b0);
      tick(4);
      check("dn_wrap", data0, 24'h235959);
      check("dn_day", day0, 1'b1);
      tick(1);
      check("dn_day_1cyc", day0, 1'b0);
      tick(3);
      check("dn_235958", data0, 24'h235958);

      // rejected loads
      run = 1'b0;
      do_load(24'h005A00, 1'b0);
      check("bad_5a_err", err0, 1'b1);
      check("bad_5a_data", data0, 24'h235958);
      tick(1);
      check("bad_err_1cyc", err0, 1'b0);
      do_load(24'h240000, 1'b0);
      check("bad_24_err", err0, 1'b1);
      check("bad_24_data", data0, 24'h235958);

      // load on a step cycle wins
      run = 1'b1;
      dir = 1'b0;
      do_load(24'h000000, 1'b0);
      tick(3);
      do_load(24'h102030, 1'b1);
      check("ld_over_step0", data0, 24'h102030);
      check("ld_over_step1", {pm1, data1}, {1'b1, 24'h102030});
      check("ld_pm_24h", pm0, 1'b0);
      tick(3);
      check("ld_pcnt_clr", data0, 24'h102030);
      tick(1);
      check("ld_then_step", data0, 24'h102031);

      // 12 h transitions
      do_load(24'h115959, 1'b0);
      tick(4);
      check("h12_noon", {pm1, data1}, {1'b1, 24'h120000});
      check("h12_noon_day", day1, 1'b0);
      do_load(24'h125959, 1'b1);
      tick(4);
      check("h12_one", {pm1, data1}, {1'b1, 24'h010000});
      check("h12_one_day", day1, 1'b0);
      do_load(24'h115959, 1'b1);
      tick(4);
      check("h12_midnight", {pm1, data1}, {1'b0, 24'h120000});
      check("h12_mid_day", day1, 1'b1);
      dir = 1'b1;
      do_load(24'h120000, 1'b1);
      tick(4);
      check("h12_dn_noon", {pm1, data1}, {1'b0, 24'h115959});
      check("h12_dn_noon_day", day1, 1'b0);
      do_load(24'h010000, 1'b0);
      tick(4);
      check("h12_dn_one", {pm1, data1}, {1'b0, 24'h125959});
      do_load(24'h120000, 1'b0);
      tick(4);
      check("h12_dn_mid", {pm1, data1}, {1'b1, 24'h115959});
      check("h12_dn_mid_day", day1, 1'b1);

      // alarm
      dir = 1'b0;
      run = 1'b0;
      alarm_set  = 1'b1;
      alarm_data = 24'h000003;
      @(negedge clk);
      alarm_set = 1'b0;
      check("alm_set_err24", err0, 1'b0);
      check("alm_set_err12", err1, ALM);
      run = 1'b1;
      do_load(24'h000001, 1'b0);
      check("alm_no_hit_load", hit0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         check($sformatf("alm_hit_c%0d", i), hit0, (ALM && i == 8));
      end
      check("alm_data", data0, 24'h000003);
      run = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         check($sformatf("alm_hold_c%0d", i), {hit0, data0}, {1'b0, 24'h000003});
      end
      do_load(24'h000003, 1'b0);
      check("alm_no_hit_reload", hit0, 1'b0);

      // asynchronous reset mid-count, with a day pulse pending
      run = 1'b1;
      do_load(24'h235959, 1'b0);
      tick(3);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_rst_data0", {day0, data0}, {1'b0, 24'h000000});
      check("async_rst_data1", {pm1, data1}, {1'b0, 24'h120000});
      @(negedge clk);
      reset = 1'b1;
      tick(3);
      check("post_rst_hold", data0, 24'h000000);
      tick(1);
      check("post_rst_step", data0, 24'h000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
